// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_if
// Purpose  : Bundle of raster timing signals between the timing generator and
//            its consumers (drawing, collision, video output).
// Signals  : pixEn      - pixel tick into the generator
//            HControl   - horizontal position (CW bits)
//            VControl   - vertical position (CW bits)
//            hsync      - horizontal sync, polarity set by the generator
//            vsync      - vertical sync, polarity set by the generator
//            videoOn    - position is inside the visible area
//            lineStart  - one-cycle strobe, HControl just became 0
//            frameStart - one-cycle strobe, position just became (0,0)
//            frameCount - completed-frame counter (8 bits, wraps)
// Modports : master = timing generator, slave = consumer / pixel-tick source
// Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic          pixEn;
    logic [CW-1:0] HControl;
    logic [CW-1:0] VControl;
    logic          hsync;
    logic          vsync;
    logic          videoOn;
    logic          lineStart;
    logic          frameStart;
    logic [7:0]    frameCount;

    modport master (
        input  pixEn,
        output HControl, VControl, hsync, vsync, videoOn,
               lineStart, frameStart, frameCount
    );

    modport slave (
        output pixEn,
        input  HControl, VControl, hsync, vsync, videoOn,
               lineStart, frameStart, frameCount
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised raster timing generator. Produces horizontal and
//            vertical position counters, sync pulses, active-video flag,
//            line/frame strobes and a frame counter for any VGA-style mode.
//            Counters advance only on clock edges where pixEn is high, so the
//            block can run from the system clock with a pixel-rate tick.
// Ports    : normalCLK - system clock, all state on the rising edge
//            reset     - asynchronous, active-high, clears all state
//            vga       - vga_timing_gen_if.master (pixEn in, timing out)
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 10
) (
    input  wire logic        normalCLK,
    input  wire logic        reset,
    vga_timing_gen_if.master vga
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] c_H_LAST     = CW'(c_H_TOTAL - 1);
    localparam logic [CW-1:0] c_V_LAST     = CW'(c_V_TOTAL - 1);
    localparam logic [CW-1:0] c_H_ACT      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_V_ACT      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_HS_FIRST   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] c_VS_FIRST   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Reject modes whose totals do not fit the counters or have empty regions.
    generate
        if ((H_ACTIVE == 0) || (H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
            (V_ACTIVE == 0) || (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0) ||
            (c_H_TOTAL > (1 << CW)) || (c_V_TOTAL > (1 << CW))) begin : g_param_error
            $error("vga_timing_gen: illegal timing parameters for CW=%0d", CW);
        end
    endgenerate

    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_video;
    logic          r_line;
    logic          r_frame;
    logic [7:0]    r_fcnt;

    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [CW-1:0] w_h_next;
    logic [CW-1:0] w_v_next;
    logic          w_hsync_next;
    logic          w_vsync_next;
    logic          w_video_next;

    assign w_h_wrap = (r_h == c_H_LAST);
    assign w_v_wrap = (r_v == c_V_LAST);
    assign w_h_next = w_h_wrap ? '0 : r_h + CW'(1);
    // Vertical position only moves on the horizontal wrap.
    assign w_v_next = w_h_wrap ? (w_v_wrap ? '0 : r_v + CW'(1)) : r_v;

    // Decode from the next position so the registered flags line up with
    // the registered counters in the same cycle.
    assign w_hsync_next = ((w_h_next >= c_HS_FIRST) && (w_h_next <= c_HS_LAST))
                          ? HSYNC_POL : ~HSYNC_POL;
    assign w_vsync_next = ((w_v_next >= c_VS_FIRST) && (w_v_next <= c_VS_LAST))
                          ? VSYNC_POL : ~VSYNC_POL;
    assign w_video_next = (w_h_next < c_H_ACT) && (w_v_next < c_V_ACT);

    always_ff @(posedge normalCLK or posedge reset) begin
        if (reset) begin
            r_h     <= '0;
            r_v     <= '0;
            r_hsync <= ~HSYNC_POL;
            r_vsync <= ~VSYNC_POL;
            r_video <= 1'b1;
            r_line  <= 1'b0;
            r_frame <= 1'b0;
            r_fcnt  <= 8'd0;
        end else if (vga.pixEn) begin
            r_h     <= w_h_next;
            r_v     <= w_v_next;
            r_hsync <= w_hsync_next;
            r_vsync <= w_vsync_next;
            r_video <= w_video_next;
            r_line  <= w_h_wrap;
            r_frame <= w_h_wrap & w_v_wrap;
            // Counter steps together with the frameStart strobe it accompanies.
            if (w_h_wrap && w_v_wrap) begin
                r_fcnt <= r_fcnt + 8'd1;
            end
        end else begin
            // Strobes are a single system-clock cycle wide whatever pixEn does.
            r_line  <= 1'b0;
            r_frame <= 1'b0;
        end
    end

    assign vga.HControl   = r_h;
    assign vga.VControl   = r_v;
    assign vga.hsync      = r_hsync;
    assign vga.vsync      = r_vsync;
    assign vga.videoOn    = r_video;
    assign vga.lineStart  = r_line;
    assign vga.frameStart = r_frame;
    assign vga.frameCount = r_fcnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Directed self-checking bench for vga_timing_gen. Four instances:
//            A default 640x480 mode, B default mode with positive sync,
//            C 8-pixel lines with default vertical timing, D 8x6 tiny mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(10)) ifA ();
    vga_timing_gen_if #(.CW(10)) ifB ();
    vga_timing_gen_if #(.CW(10)) ifC ();
    vga_timing_gen_if #(.CW(10)) ifD ();

    vga_timing_gen u_a (.normalCLK(clk), .reset(reset), .vga(ifA));

    vga_timing_gen #(.HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) u_b (
        .normalCLK(clk), .reset(reset), .vga(ifB));

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1)) u_c (
        .normalCLK(clk), .reset(reset), .vga(ifC));

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_d (
        .normalCLK(clk), .reset(reset), .vga(ifD));

    task automatic all_pix(input logic v);
        ifA.pixEn = v; ifB.pixEn = v; ifC.pixEn = v; ifD.pixEn = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        all_pix(1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        all_pix(1'b1);
        repeat (2) @(negedge clk);
        checks++; if (ifA.HControl !== 10'd0) begin errors++; $display("FAIL rst_a_h got=%0d exp=0", ifA.HControl); end
        checks++; if (ifA.VControl !== 10'd0) begin errors++; $display("FAIL rst_a_v got=%0d exp=0", ifA.VControl); end
        checks++; if (ifA.frameCount !== 8'd0) begin errors++; $display("FAIL rst_a_fc got=%0d exp=0", ifA.frameCount); end
        checks++; if (ifA.videoOn !== 1'b1) begin errors++; $display("FAIL rst_a_video got=%b exp=1", ifA.videoOn); end
        checks++; if ({ifA.hsync, ifA.vsync} !== 2'b11) begin errors++; $display("FAIL rst_a_sync got=%b exp=11", {ifA.hsync, ifA.vsync}); end
        checks++; if ({ifA.lineStart, ifA.frameStart} !== 2'b00) begin errors++; $display("FAIL rst_a_strobe got=%b exp=00", {ifA.lineStart, ifA.frameStart}); end
        checks++; if ({ifB.hsync, ifB.vsync} !== 2'b00) begin errors++; $display("FAIL rst_b_sync got=%b exp=00", {ifB.hsync, ifB.vsync}); end
        checks++; if (ifB.videoOn !== 1'b1) begin errors++; $display("FAIL rst_b_video got=%b exp=1", ifB.videoOn); end
        // Release with pixEn low: nothing moves and no strobe appears.
        all_pix(1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ifA.HControl !== 10'd0) begin errors++; $display("FAIL rel_hold_h got=%0d exp=0", ifA.HControl); end
        checks++; if ({ifA.lineStart, ifA.frameStart} !== 2'b00) begin errors++; $display("FAIL rel_strobe got=%b exp=00", {ifA.lineStart, ifA.frameStart}); end
    endtask

    task automatic test_hline();
        int eh, ev, last_ls;
        bit els;
        do_reset();
        eh = 0; ev = 0; last_ls = -1;
        for (int k = 0; k < 1700; k++) begin
            ifA.pixEn = 1'b1;
            @(negedge clk);
            els = (eh == 799);
            if (els) begin eh = 0; ev = ev + 1; end else eh = eh + 1;
            checks++; if (ifA.HControl !== 10'(eh)) begin errors++; $display("FAIL hline_h k=%0d got=%0d exp=%0d", k, ifA.HControl, eh); end
            checks++; if (ifA.VControl !== 10'(ev)) begin errors++; $display("FAIL hline_v k=%0d got=%0d exp=%0d", k, ifA.VControl, ev); end
            checks++; if (ifA.hsync !== !(eh >= 656 && eh <= 751)) begin errors++; $display("FAIL hline_hsync h=%0d got=%b", eh, ifA.hsync); end
            checks++; if (ifA.videoOn !== (eh < 640 && ev < 480)) begin errors++; $display("FAIL hline_video h=%0d got=%b", eh, ifA.videoOn); end
            checks++; if (ifA.lineStart !== els) begin errors++; $display("FAIL hline_ls k=%0d got=%b exp=%b", k, ifA.lineStart, els); end
            checks++; if (ifA.frameStart !== 1'b0) begin errors++; $display("FAIL hline_fs k=%0d got=%b exp=0", k, ifA.frameStart); end
            if (els) begin
                if (last_ls >= 0) begin
                    checks++; if (k - last_ls != 800) begin errors++; $display("FAIL hline_period got=%0d exp=800", k - last_ls); end
                end
                last_ls = k;
            end
        end
        ifA.pixEn = 1'b0;
    endtask

    task automatic test_polarity();
        int eh;
        do_reset();
        eh = 0;
        for (int k = 0; k < 800; k++) begin
            ifB.pixEn = 1'b1;
            @(negedge clk);
            eh = (eh == 799) ? 0 : eh + 1;
            checks++; if (ifB.HControl !== 10'(eh)) begin errors++; $display("FAIL pol_h k=%0d got=%0d exp=%0d", k, ifB.HControl, eh); end
            checks++; if (ifB.hsync !== (eh >= 656 && eh <= 751)) begin errors++; $display("FAIL pol_hsync h=%0d got=%b", eh, ifB.hsync); end
            checks++; if (ifB.vsync !== 1'b0) begin errors++; $display("FAIL pol_vsync h=%0d got=%b exp=0", eh, ifB.vsync); end
        end
        ifB.pixEn = 1'b0;
    endtask

    task automatic test_pixen_toggle();
        int eh, ev, last_ls;
        bit en, els;
        do_reset();
        eh = 0; ev = 0; last_ls = -1;
        for (int k = 0; k < 3300; k++) begin
            en = (k % 2 == 0);
            ifA.pixEn = en;
            @(negedge clk);
            els = 1'b0;
            if (en) begin
                els = (eh == 799);
                if (els) begin eh = 0; ev = ev + 1; end else eh = eh + 1;
            end
            checks++; if (ifA.HControl !== 10'(eh)) begin errors++; $display("FAIL tog_h k=%0d got=%0d exp=%0d", k, ifA.HControl, eh); end
            checks++; if (ifA.VControl !== 10'(ev)) begin errors++; $display("FAIL tog_v k=%0d got=%0d exp=%0d", k, ifA.VControl, ev); end
            checks++; if (ifA.hsync !== !(eh >= 656 && eh <= 751)) begin errors++; $display("FAIL tog_hsync k=%0d got=%b", k, ifA.hsync); end
            checks++; if (ifA.videoOn !== (eh < 640 && ev < 480)) begin errors++; $display("FAIL tog_video k=%0d got=%b", k, ifA.videoOn); end
            checks++; if (ifA.lineStart !== els) begin errors++; $display("FAIL tog_ls k=%0d got=%b exp=%b", k, ifA.lineStart, els); end
            checks++; if (ifA.frameStart !== 1'b0) begin errors++; $display("FAIL tog_fs k=%0d got=%b exp=0", k, ifA.frameStart); end
            if (els) begin
                if (last_ls >= 0) begin
                    checks++; if (k - last_ls != 1600) begin errors++; $display("FAIL tog_period got=%0d exp=1600", k - last_ls); end
                end
                last_ls = k;
            end
        end
        ifA.pixEn = 1'b0;
    endtask

    task automatic test_frame();
        int eh, ev, efc, last_fs;
        bit hw, vw;
        do_reset();
        eh = 0; ev = 0; efc = 0; last_fs = -1;
        for (int k = 0; k < 12600; k++) begin
            ifC.pixEn = 1'b1;
            @(negedge clk);
            hw = (eh == 7);
            vw = hw && (ev == 524);
            eh = hw ? 0 : eh + 1;
            if (hw) ev = vw ? 0 : ev + 1;
            if (vw) efc = efc + 1;
            checks++; if (ifC.HControl !== 10'(eh)) begin errors++; $display("FAIL frm_h k=%0d got=%0d exp=%0d", k, ifC.HControl, eh); end
            checks++; if (ifC.VControl !== 10'(ev)) begin errors++; $display("FAIL frm_v k=%0d got=%0d exp=%0d", k, ifC.VControl, ev); end
            checks++; if (ifC.vsync !== !(ev >= 490 && ev <= 491)) begin errors++; $display("FAIL frm_vsync v=%0d got=%b", ev, ifC.vsync); end
            checks++; if (ifC.lineStart !== hw) begin errors++; $display("FAIL frm_ls k=%0d got=%b exp=%b", k, ifC.lineStart, hw); end
            checks++; if (ifC.frameStart !== vw) begin errors++; $display("FAIL frm_fs k=%0d got=%b exp=%b", k, ifC.frameStart, vw); end
            checks++; if (ifC.frameCount !== 8'(efc)) begin errors++; $display("FAIL frm_fc k=%0d got=%0d exp=%0d", k, ifC.frameCount, efc); end
            if (vw) begin
                if (last_fs >= 0) begin
                    checks++; if (k - last_fs != 4200) begin errors++; $display("FAIL frm_period got=%0d exp=4200", k - last_fs); end
                end
                last_fs = k;
            end
        end
        checks++; if (ifC.frameCount !== 8'd3) begin errors++; $display("FAIL frm_three got=%0d exp=3", ifC.frameCount); end
    endtask

    task automatic test_small();
        int eh, ev, efc;
        bit hw, vw;
        do_reset();
        eh = 0; ev = 0; efc = 0;
        for (int k = 0; k < 256 * 48; k++) begin
            ifD.pixEn = 1'b1;
            @(negedge clk);
            hw = (eh == 7);
            vw = hw && (ev == 5);
            eh = hw ? 0 : eh + 1;
            if (hw) ev = vw ? 0 : ev + 1;
            if (vw) efc = efc + 1;
            checks++; if (ifD.HControl !== 10'(eh)) begin errors++; $display("FAIL sm_h k=%0d got=%0d exp=%0d", k, ifD.HControl, eh); end
            checks++; if (ifD.VControl !== 10'(ev)) begin errors++; $display("FAIL sm_v k=%0d got=%0d exp=%0d", k, ifD.VControl, ev); end
            checks++; if (ifD.hsync !== !(eh >= 5 && eh <= 6)) begin errors++; $display("FAIL sm_hsync h=%0d v=%0d got=%b", eh, ev, ifD.hsync); end
            checks++; if (ifD.vsync !== !(ev == 4)) begin errors++; $display("FAIL sm_vsync h=%0d v=%0d got=%b", eh, ev, ifD.vsync); end
            checks++; if (ifD.videoOn !== (eh < 4 && ev < 3)) begin errors++; $display("FAIL sm_video h=%0d v=%0d got=%b", eh, ev, ifD.videoOn); end
            checks++; if (ifD.frameStart !== vw) begin errors++; $display("FAIL sm_fs k=%0d got=%b exp=%b", k, ifD.frameStart, vw); end
            checks++; if (ifD.frameCount !== 8'(efc)) begin errors++; $display("FAIL sm_fc k=%0d got=%0d exp=%0d", k, ifD.frameCount, 8'(efc)); end
        end
        checks++; if (ifD.frameCount !== 8'd0) begin errors++; $display("FAIL sm_fc_wrap got=%0d exp=0", ifD.frameCount); end
        ifD.pixEn = 1'b0;
    endtask

    // Continues from test_frame: instance C sits at (0,0) with frameCount=3.
    task automatic test_reset_midframe();
        int eh, ev;
        bit hw, vw;
        ifC.pixEn = 1'b1;
        repeat (200 * 8 + 5) @(negedge clk);
        checks++; if ({ifC.HControl, ifC.VControl} !== {10'd5, 10'd200}) begin errors++; $display("FAIL mid_pos got=%0d,%0d exp=5,200", ifC.HControl, ifC.VControl); end
        checks++; if (ifC.frameCount !== 8'd3) begin errors++; $display("FAIL mid_fc_pre got=%0d exp=3", ifC.frameCount); end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if ({ifC.HControl, ifC.VControl} !== 20'd0) begin errors++; $display("FAIL mid_async_pos got=%0d,%0d exp=0,0", ifC.HControl, ifC.VControl); end
        checks++; if (ifC.frameCount !== 8'd0) begin errors++; $display("FAIL mid_async_fc got=%0d exp=0", ifC.frameCount); end
        checks++; if ({ifC.hsync, ifC.vsync, ifC.videoOn, ifC.lineStart, ifC.frameStart} !== 5'b11100) begin errors++; $display("FAIL mid_async_flags got=%b exp=11100", {ifC.hsync, ifC.vsync, ifC.videoOn, ifC.lineStart, ifC.frameStart}); end
        @(negedge clk);
        reset = 1'b0;
        checks++; if (ifC.HControl !== 10'd0) begin errors++; $display("FAIL mid_held_h got=%0d exp=0", ifC.HControl); end
        eh = 0; ev = 0;
        for (int k = 0; k < 4200; k++) begin
            @(negedge clk);
            hw = (eh == 7);
            vw = hw && (ev == 524);
            eh = hw ? 0 : eh + 1;
            if (hw) ev = vw ? 0 : ev + 1;
            if (k < 3) begin
                checks++; if (ifC.HControl !== 10'(k + 1)) begin errors++; $display("FAIL mid_count k=%0d got=%0d exp=%0d", k, ifC.HControl, k + 1); end
            end
            checks++; if (ifC.frameStart !== (k == 4199)) begin errors++; $display("FAIL mid_fs k=%0d got=%b exp=%b", k, ifC.frameStart, k == 4199); end
            checks++; if (ifC.lineStart !== hw) begin errors++; $display("FAIL mid_ls k=%0d got=%b exp=%b", k, ifC.lineStart, hw); end
        end
        checks++; if (ifC.frameCount !== 8'd1) begin errors++; $display("FAIL mid_fc_post got=%0d exp=1", ifC.frameCount); end
        ifC.pixEn = 1'b0;
    endtask

    initial begin
        all_pix(1'b0);
        test_reset();
        test_hline();
        test_polarity();
        test_pixen_toggle();
        test_frame();
        test_reset_midframe();
        test_small();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
